// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions: ALU/op-type encodings, fetch constants,
// fetch state and the instruction-buffer entry layout.
package fetch_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_SYSTEM
    } op_type_t;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Word-align an address (mask form so every input bit is consumed).
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, inst}. Push on a full buffer
// is accepted when a pop happens in the same cycle. Flush empties it.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Entry storage; contents are only observed when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: issues sequential word reads to a one-cycle-latency instruction
// memory, buffers returned words with their PCs and hands them to the decoder.
// Handles redirect (flush + restart) and halt (stop fetching, drain buffer).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t   state_q;
    logic [31:0]    pc_q;
    logic [31:0]    req_pc_q;
    logic           inflight_q;
    logic           req_epoch_q;
    logic           epoch_q;

    logic           pop;
    logic           push;
    logic           resp_ok;
    logic [CW:0]    occ;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    fetch_entry_t   fifo_din;
    fetch_entry_t   fifo_dout;

    // Occupancy counts the outstanding read so a response always has a slot.
    assign pop       = dec_valid && dec_ready;
    assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign imem_req  = rst_n && (state_q == FETCH_RUN) && !redirect && (occ < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    // A response is kept only if it belongs to the current epoch and no flush is happening.
    assign resp_ok  = inflight_q && (req_epoch_q == epoch_q) && !redirect;
    assign push     = resp_ok && (!fifo_full || pop);
    assign fifo_din = '{pc: req_pc_q, inst: imem_rdata};

    assign dec_valid = !fifo_empty;
    assign dec_inst  = fifo_empty ? INST_NOP : fifo_dout.inst;
    assign dec_pc    = fifo_empty ? 32'h0    : fifo_dout.pc;

    // Run/halt control; redirect always restarts fetching and beats halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_RUN:    if (!redirect && halt) state_q <= FETCH_HALTED;
                FETCH_HALTED: if (redirect)          state_q <= FETCH_RUN;
                default:                             state_q <= FETCH_RUN;
            endcase
        end
    end

    // PC, in-flight tracking and epoch; redirect reloads PC and retires the old epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                req_pc_q    <= pc_q;
                req_epoch_q <= epoch_q;
            end
            if (redirect) begin
                pc_q    <= align_pc(redirect_pc);
                epoch_q <= ~epoch_q;
            end else if (imem_req) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, mid-operation reset, a
// wrap-around instance, and randomized traffic against a queue-based model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          D       = 2;
    localparam logic [31:0] RPC     = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, dec_valid, dec_ready, redirect, halt;
    logic [31:0] imem_addr, imem_rdata, dec_inst, dec_pc, redirect_pc;

    logic        w_req, w_valid, w_ready, w_redirect, w_halt;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_rpc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .dec_valid(w_valid), .dec_ready(w_ready),
        .dec_inst(w_inst), .dec_pc(w_pc), .redirect(w_redirect),
        .redirect_pc(w_rpc), .halt(w_halt)
    );

    // Memory contents: address 0 holds a real instruction, others a recognisable pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00b5_0633;
        return a ^ 32'h5A00_0013;
    endfunction

    // One-cycle-latency instruction memories.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        w_rdata    <= w_req    ? mem_word(w_addr)    : 32'hDEAD_BEEF;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: buffered instructions as a queue, one pending read.
    fetch_entry_t m_q[$];
    bit           m_run, m_pend;
    logic [31:0]  m_pc, m_pend_pc;
    bit           c_rdy, c_rd, c_hl;
    logic [31:0]  c_rp;

    task automatic m_reset();
        m_q.delete();
        m_run = 1; m_pend = 0; m_pc = RPC; m_pend_pc = '0;
    endtask

    task automatic apply(input bit rdy, input bit rd, input logic [31:0] rp, input bit hl);
        dec_ready = rdy; redirect = rd; redirect_pc = rp; halt = hl;
        c_rdy = rdy; c_rd = rd; c_rp = rp; c_hl = hl;
        #1;
    endtask

    task automatic finish_cycle();
        bit pop, req;
        int occ;
        fetch_entry_t e;
        pop = (m_q.size() > 0) && c_rdy;
        occ = m_q.size() + int'(m_pend) - int'(pop);
        req = m_run && !c_rd && (occ < D);
        chk("m_valid", dec_valid, m_q.size() > 0);
        chk("m_inst",  dec_inst,  m_q.size() > 0 ? m_q[0].inst : INST_NOP);
        chk("m_pc",    dec_pc,    m_q.size() > 0 ? m_q[0].pc   : 32'h0);
        chk("m_req",   imem_req,  req);
        chk("m_addr",  imem_addr, m_pc);
        if (pop) void'(m_q.pop_front());
        if (c_rd) m_q.delete();
        else if (m_pend) begin
            e.pc = m_pend_pc; e.inst = mem_word(m_pend_pc);
            m_q.push_back(e);
        end
        m_pend = req; m_pend_pc = m_pc;
        if (c_rd) begin
            m_pc = c_rp & 32'hFFFF_FFFC; m_run = 1;
        end else begin
            if (req) m_pc = m_pc + 32'd4;
            if (c_hl) m_run = 0;
        end
        @(negedge clk);
    endtask

    task automatic step(input bit rdy, input bit rd, input logic [31:0] rp, input bit hl);
        apply(rdy, rd, rp, hl);
        finish_cycle();
    endtask

    typedef struct {
        bit          rdy, rd, hl;
        logic [31:0] rp;
        bit          e_v, e_req;
        logic [31:0] e_pc, e_addr;
    } tv_t;

    function automatic tv_t mk(bit rdy, bit rd, logic [31:0] rp, bit hl,
                               bit ev, logic [31:0] epc, bit ereq, logic [31:0] eaddr);
        tv_t t;
        t.rdy = rdy; t.rd = rd; t.rp = rp; t.hl = hl;
        t.e_v = ev; t.e_pc = epc; t.e_req = ereq; t.e_addr = eaddr;
        return t;
    endfunction

    localparam int NT = 24;
    tv_t tv [NT];

    initial begin
        // stream, backpressure, halt at pc 8, drain, redirect 0x40, redirect 0x103 with a read in flight
        tv[0]  = mk(1,0,0,0,         0,32'h000,1,32'h000);
        tv[1]  = mk(1,0,0,0,         0,32'h000,1,32'h004);
        tv[2]  = mk(1,0,0,0,         1,32'h000,1,32'h008);
        tv[3]  = mk(1,0,0,0,         1,32'h004,1,32'h00C);
        tv[4]  = mk(0,0,0,0,         1,32'h008,0,32'h010);
        tv[5]  = mk(0,0,0,0,         1,32'h008,0,32'h010);
        tv[6]  = mk(0,0,0,0,         1,32'h008,0,32'h010);
        tv[7]  = mk(0,0,0,0,         1,32'h008,0,32'h010);
        tv[8]  = mk(0,0,0,1,         1,32'h008,0,32'h010);
        tv[9]  = mk(1,0,0,0,         1,32'h008,0,32'h010);
        tv[10] = mk(1,0,0,0,         1,32'h00C,0,32'h010);
        tv[11] = mk(1,0,0,0,         0,32'h000,0,32'h010);
        tv[12] = mk(1,1,32'h40,0,    0,32'h000,0,32'h010);
        tv[13] = mk(1,0,0,0,         0,32'h000,1,32'h040);
        tv[14] = mk(1,0,0,0,         0,32'h000,1,32'h044);
        tv[15] = mk(1,0,0,0,         1,32'h040,1,32'h048);
        tv[16] = mk(1,1,32'h103,0,   1,32'h044,0,32'h04C);
        tv[17] = mk(1,0,0,0,         0,32'h000,1,32'h100);
        tv[18] = mk(1,0,0,0,         0,32'h000,1,32'h104);
        tv[19] = mk(1,0,0,0,         1,32'h100,1,32'h108);
        tv[20] = mk(1,0,0,0,         1,32'h104,1,32'h10C);
        tv[21] = mk(0,0,0,0,         1,32'h108,0,32'h110);
        tv[22] = mk(1,0,0,0,         1,32'h108,1,32'h110);
        tv[23] = mk(1,0,0,0,         1,32'h10C,1,32'h114);

        rst_n = 1'b0;
        dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        w_ready = 1'b1; w_redirect = 1'b0; w_rpc = '0; w_halt = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_inst",  dec_inst,  32'h0000_0013);
        chk("rst_pc",    dec_pc,    32'h0);
        chk("rst_addr",  imem_addr, RPC);
        chk("rst_req",   imem_req,  1'b0);
        chk("rst_waddr", w_addr,    WRAP_PC);

        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < NT; i++) begin
            apply(tv[i].rdy, tv[i].rd, tv[i].rp, tv[i].hl);
            chk($sformatf("tv%0d_valid", i), dec_valid, tv[i].e_v);
            chk($sformatf("tv%0d_pc", i),    dec_pc,    tv[i].e_pc);
            chk($sformatf("tv%0d_inst", i),  dec_inst,  tv[i].e_v ? mem_word(tv[i].e_pc) : INST_NOP);
            chk($sformatf("tv%0d_req", i),   imem_req,  tv[i].e_req);
            chk($sformatf("tv%0d_addr", i),  imem_addr, tv[i].e_addr);
            if (i == 2) chk("stream_first_inst", dec_inst, 32'h00b5_0633);
            if (i == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
            if (i == 1) chk("wrap_addr1", w_addr, 32'h0000_0000);
            if (i == 2) begin
                chk("wrap_valid", w_valid, 1'b1);
                chk("wrap_pc0",   w_pc,    32'hFFFF_FFFC);
                chk("wrap_inst0", w_inst,  mem_word(32'hFFFF_FFFC));
            end
            if (i == 3) chk("wrap_pc1", w_pc, 32'h0000_0000);
            finish_cycle();
        end

        // Short asynchronous reset pulse while a read is outstanding.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dec_valid, 1'b0);
        chk("mid_rst_inst",  dec_inst,  INST_NOP);
        chk("mid_rst_addr",  imem_addr, RPC);
        chk("mid_rst_req",   imem_req,  1'b0);
        #1;
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rdy, rd, hl;
            logic [31:0] rp;
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 19) == 0);
            hl  = ($urandom_range(0, 24) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(rdy, rd, rp, hl);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
